// File: rtl/des_key_sched_ctrl_pkg.sv
// Shared constants for the DES key-schedule sequencer: fixed DES widths,
// PC-1/PC-2 tables (1-based, FIPS 46 numbering) and the sequencer states.
package des_key_sched_ctrl_pkg;

   localparam int KEY_W  = 64;
   localparam int ROUNDS = 16;
   localparam int CD_W   = 28;
   localparam int SK_W   = 48;

   // Entry j names the key bit (1 = MSB) that lands in output bit j.
   localparam int PC1_TABLE [1:56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   // Entry j names the C||D bit (1 = MSB) that lands in subkey bit j.
   localparam int PC2_TABLE [1:48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// Host-side bus of the key-schedule sequencer: key load handshake plus the
// subkey read port used by the round datapath.
interface des_key_sched_ctrl_if;
   import des_key_sched_ctrl_pkg::*;

   logic             key_valid;
   logic             key_ready;
   logic [KEY_W-1:0] key_in;
   logic             rd_en;
   logic [3:0]       rd_round;
   logic             rd_decrypt;
   logic [SK_W-1:0]  rd_data;
   logic             rd_vld;

   modport master (
      output key_valid, key_in, rd_en, rd_round, rd_decrypt,
      input  key_ready, rd_data, rd_vld
   );

   modport slave (
      input  key_valid, key_in, rd_en, rd_round, rd_decrypt,
      output key_ready, rd_data, rd_vld
   );
endinterface

// File: rtl/des_key_sched_ctrl_pc2.sv
// PC-2: combinational 56->48 permutation of C||D into one round subkey.
module des_key_sched_ctrl_pc2
   import des_key_sched_ctrl_pkg::*;
(
   input  logic [2*CD_W-1:0] cd,
   output logic [SK_W-1:0]   subkey
);
   // PC-2 drops C/D bits 9,18,22,25,35,38,43,54 by definition.
   logic unused_cd;
   assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

   generate
      for (genvar gi = 1; gi <= SK_W; gi++) begin : g_pc2
         assign subkey[SK_W-gi] = cd[2*CD_W-PC2_TABLE[gi]];
      end
   endgenerate
endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer: applies PC-1 to an accepted key, streams round
// ids 1..16 to the pipelined rotation stage, stores PC-2 of every returned
// Ci/Di as K1..K16 and serves them in forward or reverse order.
module des_key_sched_ctrl
   import des_key_sched_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   des_key_sched_ctrl_if.slave bus,
   output logic                ll_start,
   output logic [5:0]          ll_keyid,
   output logic [CD_W-1:0]     ll_C0,
   output logic [CD_W-1:0]     ll_D0,
   input  logic [CD_W-1:0]     ll_Ci,
   input  logic [CD_W-1:0]     ll_Di,
   output logic                busy,
   output logic                keys_valid
);
   state_t              state_reg;
   logic                key_ready_reg;
   logic [2*CD_W-1:0]   pc1_out;
   logic [SK_W-1:0]     pc2_out;
   logic [SK_W-1:0]     regfile [ROUNDS];
   logic                cap_en;
   logic [3:0]          cap_idx;
   logic [3:0]          rd_idx;
   logic                unused_parity;

   // Parity bits 8,16..64 never reach PC-1.
   assign unused_parity = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40], bus.key_in[32],
                            bus.key_in[24], bus.key_in[16], bus.key_in[8], bus.key_in[0]};

   generate
      for (genvar gi = 1; gi <= 2*CD_W; gi++) begin : g_pc1
         assign pc1_out[2*CD_W-gi] = bus.key_in[KEY_W-PC1_TABLE[gi]];
      end
   endgenerate

   des_key_sched_ctrl_pc2 u_pc2 (
      .cd     ({ll_Ci, ll_Di}),
      .subkey (pc2_out)
   );

   assign bus.key_ready = key_ready_reg;

   // Ci/Di for keyid n arrive one cycle after issue, so slot n-2 is written while n is issued; DRAIN catches K16.
   always_comb begin
      cap_en  = 1'b0;
      cap_idx = 4'd0;
      if (state_reg == ISSUE && ll_keyid >= 6'd2) begin
         cap_en  = 1'b1;
         cap_idx = 4'(ll_keyid - 6'd2);
      end else if (state_reg == DRAIN) begin
         cap_en  = 1'b1;
         cap_idx = 4'(ROUNDS - 1);
      end
   end

   // Decrypt walks the schedule backwards: round r uses K(16-r).
   assign rd_idx = bus.rd_decrypt ? 4'(ROUNDS - 1) - bus.rd_round : bus.rd_round;

   // Sequencer FSM; ll_keyid doubles as the round counter n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         key_ready_reg <= 1'b1;
         busy          <= 1'b0;
         keys_valid    <= 1'b0;
         ll_start      <= 1'b0;
         ll_keyid      <= '0;
         ll_C0         <= '0;
         ll_D0         <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.key_valid) begin
                  ll_C0         <= pc1_out[2*CD_W-1:CD_W];
                  ll_D0         <= pc1_out[CD_W-1:0];
                  keys_valid    <= 1'b0;
                  busy          <= 1'b1;
                  key_ready_reg <= 1'b0;
                  ll_start      <= 1'b1;
                  ll_keyid      <= 6'd1;
                  state_reg     <= ISSUE;
               end
            end
            ISSUE: begin
               if (ll_keyid == 6'(ROUNDS)) begin
                  ll_start  <= 1'b0;
                  ll_keyid  <= '0;
                  state_reg <= DRAIN;
               end else begin
                  ll_keyid <= ll_keyid + 6'd1;
               end
            end
            DRAIN: begin
               state_reg <= DONE;
            end
            DONE: begin
               keys_valid    <= 1'b1;
               busy          <= 1'b0;
               key_ready_reg <= 1'b1;
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Subkey register file; reset discards any partial schedule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROUNDS; i++) begin
            regfile[i] <= '0;
         end
      end else if (cap_en) begin
         regfile[cap_idx] <= pc2_out;
      end
   end

   // Registered read port; returns zero until a full schedule is stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data <= '0;
         bus.rd_vld  <= 1'b0;
      end else begin
         bus.rd_vld  <= bus.rd_en;
         bus.rd_data <= keys_valid ? regfile[rd_idx] : '0;
      end
   end
endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl: models the rotation stage and
// computes the DES key schedule independently from the FIPS 46 tables.
module tb_des_key_sched_ctrl;

   localparam logic [63:0] SPEC_KEY = 64'h133457799BBCDFF1;
   localparam logic [47:0] SPEC_K1  = 48'h1B02EFFC7072;
   localparam logic [47:0] SPEC_K16 = 48'hCB3D8B0E17F5;
   localparam logic [63:0] PARITY   = 64'h0101010101010101;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ll_start;
   logic [5:0]  ll_keyid;
   logic [27:0] ll_C0, ll_D0;
   logic [27:0] ll_Ci = '0;
   logic [27:0] ll_Di = '0;
   logic        busy, keys_valid;

   int tests  = 0;
   int failed = 0;

   logic [47:0] exp_k [16];
   logic [27:0] exp_c0, exp_d0;

   des_key_sched_ctrl_if bus ();

   des_key_sched_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ll_start   (ll_start),
      .ll_keyid   (ll_keyid),
      .ll_C0      (ll_C0),
      .ll_D0      (ll_D0),
      .ll_Ci      (ll_Ci),
      .ll_Di      (ll_Di),
      .busy       (busy),
      .keys_valid (keys_valid)
   );

   always #5 clk = ~clk;

   function automatic int cum_shift(input int k);
      int s = 0;
      int kk = (k > 16) ? 16 : k;
      for (int i = 0; i < kk; i++) s += SHIFTS[i];
      return s;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
      logic [55:0] t;
      t = {x, x} << s;
      return t[55:28];
   endfunction

   // Rotation stage: answers each start one cycle later, garbage otherwise.
   always @(posedge clk) begin
      if (ll_start) begin
         ll_Ci <= rotl28(ll_C0, cum_shift(int'(ll_keyid)));
         ll_Di <= rotl28(ll_D0, cum_shift(int'(ll_keyid)));
      end else begin
         ll_Ci <= 28'($urandom);
         ll_Di <= 28'($urandom);
      end
   end

   // Reference key schedule: PC-1, iterated left shifts, PC-2.
   task automatic compute_ref(input logic [63:0] key);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [55:0] cdn;
      for (int j = 1; j <= 56; j++) cd[56-j] = key[64-PC1[j-1]];
      c = cd[55:28];
      d = cd[27:0];
      exp_c0 = c;
      exp_d0 = d;
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < SHIFTS[r]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cdn = {c, d};
         for (int j = 1; j <= 48; j++) exp_k[r][48-j] = cdn[56-PC2[j-1]];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [63:0] key);
      int cyc = 0;
      while (bus.key_ready !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      if (bus.key_ready !== 1'b1) begin
         tests++;
         failed++;
         $display("FAIL key_ready_timeout: key_ready=%b required 1", bus.key_ready);
      end
      bus.key_in    = key;
      bus.key_valid = 1'b1;
      tick();
      bus.key_valid = 1'b0;
   endtask

   task automatic wait_keys_valid(output int cyc);
      cyc = 0;
      while (keys_valid !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
      end
      if (keys_valid !== 1'b1) begin
         tests++;
         failed++;
         $display("FAIL keys_valid_timeout: keys_valid=%b required 1", keys_valid);
      end
   endtask

   task automatic do_read(input int r, input bit dec, output logic [47:0] data, output logic vld);
      bus.rd_en      = 1'b1;
      bus.rd_round   = 4'(r);
      bus.rd_decrypt = dec;
      tick();
      data = bus.rd_data;
      vld  = bus.rd_vld;
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [47:0] d;
      logic        v;
      bus.key_valid  = 1'b0;
      bus.key_in     = '0;
      bus.rd_en      = 1'b0;
      bus.rd_round   = '0;
      bus.rd_decrypt = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      tests++;
      if ({bus.key_ready, busy, keys_valid, ll_start, ll_keyid, ll_C0, ll_D0, bus.rd_data, bus.rd_vld}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 28'd0, 28'd0, 48'd0, 1'b0}) begin
         failed++;
         $display("FAIL reset_values: ready=%b busy=%b kv=%b start=%b keyid=%0d C0=%h D0=%h rd=%h vld=%b required ready=1 rest 0",
                  bus.key_ready, busy, keys_valid, ll_start, ll_keyid, ll_C0, ll_D0, bus.rd_data, bus.rd_vld);
      end
      rst_n = 1'b1;
      tick();
      do_read($urandom_range(0, 15), 1'($urandom_range(0, 1)), d, v);
      tests++;
      if ({v, d} !== {1'b1, 48'd0}) begin
         failed++;
         $display("FAIL read_before_keys: vld=%b data=%h required vld=1 data=0", v, d);
      end
      $display("[TB] reset checked, read before any schedule returned %h", d);
   endtask

   task automatic test_load_timing();
      int cyc;
      compute_ref(SPEC_KEY);
      load_key(SPEC_KEY);
      tests++;
      if ({ll_C0, ll_D0} !== {28'hF0CCAAF, 28'h556678F}) begin
         failed++;
         $display("FAIL pc1_spec: C0=%h D0=%h required F0CCAAF 556678F", ll_C0, ll_D0);
      end
      tests++;
      if ({bus.key_ready, busy, keys_valid} !== 3'b010) begin
         failed++;
         $display("FAIL accept_flags: ready/busy/kv=%b required 010", {bus.key_ready, busy, keys_valid});
      end
      for (int k = 1; k <= 16; k++) begin
         tests++;
         if (ll_start !== 1'b1 || ll_keyid !== 6'(k)) begin
            failed++;
            $display("FAIL keyid_seq: start=%b keyid=%0d required start=1 keyid=%0d", ll_start, ll_keyid, k);
         end
         tick();
      end
      tests++;
      if (ll_start !== 1'b0 || ll_keyid !== 6'd0) begin
         failed++;
         $display("FAIL keyid_end: start=%b keyid=%0d required 0 0", ll_start, ll_keyid);
      end
      wait_keys_valid(cyc);
      cyc += 16;
      tests++;
      if (cyc !== 18) begin
         failed++;
         $display("FAIL kv_latency: keys_valid after %0d edges required 18", cyc);
      end
      tests++;
      if ({bus.key_ready, busy} !== 2'b10) begin
         failed++;
         $display("FAIL done_flags: ready/busy=%b required 10", {bus.key_ready, busy});
      end
      $display("[TB] spec key loaded, keys_valid after %0d edges", cyc);
   endtask

   task automatic test_read_forward();
      logic [47:0] d;
      logic        v;
      do_read(0, 1'b0, d, v);
      tests++;
      if (d !== SPEC_K1 || v !== 1'b1) begin
         failed++;
         $display("FAIL k1_fwd: data=%h vld=%b required %h 1", d, v, SPEC_K1);
      end
      tick();
      tests++;
      if (bus.rd_vld !== 1'b0) begin
         failed++;
         $display("FAIL rd_vld_drop: vld=%b required 0", bus.rd_vld);
      end
      do_read(15, 1'b0, d, v);
      tests++;
      if (d !== SPEC_K16) begin
         failed++;
         $display("FAIL k16_fwd: data=%h required %h", d, SPEC_K16);
      end
      for (int i = 0; i < 16; i++) begin
         int r = $urandom_range(0, 15);
         bit dec = 1'($urandom_range(0, 1));
         int kn = dec ? 16 - r : r + 1;
         do_read(r, dec, d, v);
         tests++;
         if (d !== exp_k[kn-1] || v !== 1'b1) begin
            failed++;
            $display("FAIL rand_read: round=%0d dec=%0d data=%h vld=%b required K%0d=%h", r, dec, d, v, kn, exp_k[kn-1]);
         end
      end
      $display("[TB] forward and random-order reads done");
   endtask

   task automatic test_reverse_b2b();
      bus.rd_en      = 1'b1;
      bus.rd_decrypt = 1'b1;
      for (int r = 0; r < 16; r++) begin
         bus.rd_round = 4'(r);
         tick();
         tests++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== exp_k[15-r]) begin
            failed++;
            $display("FAIL rev_read: round=%0d vld=%b data=%h required 1 %h", r, bus.rd_vld, bus.rd_data, exp_k[15-r]);
         end
         if (r == 0) begin
            tests++;
            if (bus.rd_data !== SPEC_K16) begin
               failed++;
               $display("FAIL rev_round0: data=%h required %h", bus.rd_data, SPEC_K16);
            end
         end
      end
      bus.rd_en = 1'b0;
      tick();
      tests++;
      if (bus.rd_vld !== 1'b0) begin
         failed++;
         $display("FAIL rev_vld_drop: vld=%b required 0", bus.rd_vld);
      end
      bus.rd_decrypt = 1'b0;
      $display("[TB] back-to-back reverse reads done");
   endtask

   task automatic test_busy_ignore();
      logic [63:0] key_a, key_b;
      logic [27:0] ca, da;
      logic [47:0] d;
      logic        v;
      int          cyc;
      bit          held;
      key_a = {$urandom, $urandom};
      key_b = {$urandom, $urandom};
      compute_ref(key_a);
      ca = exp_c0;
      da = exp_d0;
      load_key(key_a);
      bus.key_in    = key_b;
      bus.key_valid = 1'b1;
      held = 1'b1;
      cyc  = 0;
      while (keys_valid !== 1'b1 && cyc < 60) begin
         if ({ll_C0, ll_D0} !== {ca, da} || bus.key_ready !== 1'b0) held = 1'b0;
         tick();
         cyc++;
      end
      tests++;
      if (!held || cyc !== 18) begin
         failed++;
         $display("FAIL busy_ignore: C0/D0 held=%0d, keys_valid after %0d edges required held=1 18", held, cyc);
      end
      tick();
      bus.key_valid = 1'b0;
      compute_ref(key_b);
      tests++;
      if ({keys_valid, busy, ll_C0, ll_D0} !== {1'b0, 1'b1, exp_c0, exp_d0}) begin
         failed++;
         $display("FAIL second_accept: kv=%b busy=%b C0=%h D0=%h required 0 1 %h %h", keys_valid, busy, ll_C0, ll_D0, exp_c0, exp_d0);
      end
      do_read($urandom_range(0, 15), 1'b0, d, v);
      tests++;
      if ({v, d} !== {1'b1, 48'd0}) begin
         failed++;
         $display("FAIL read_while_busy: vld=%b data=%h required 1 0", v, d);
      end
      wait_keys_valid(cyc);
      for (int r = 0; r < 16; r++) begin
         do_read(r, 1'b0, d, v);
         tests++;
         if (d !== exp_k[r]) begin
            failed++;
            $display("FAIL second_key_K%0d: data=%h required %h", r + 1, d, exp_k[r]);
         end
      end
      $display("[TB] key %h held during generation, then accepted", key_b);
   endtask

   task automatic test_reset_mid();
      logic [47:0] d;
      logic        v;
      int          cyc;
      compute_ref(SPEC_KEY);
      load_key(SPEC_KEY);
      cyc = 0;
      while (ll_keyid !== 6'd9 && cyc < 30) begin
         tick();
         cyc++;
      end
      tests++;
      if (ll_keyid !== 6'd9) begin
         failed++;
         $display("FAIL reach_n9: keyid=%0d required 9", ll_keyid);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.key_ready, busy, keys_valid, ll_start, ll_keyid, ll_C0, ll_D0, bus.rd_data, bus.rd_vld}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 28'd0, 28'd0, 48'd0, 1'b0}) begin
         failed++;
         $display("FAIL mid_reset: ready=%b busy=%b kv=%b start=%b keyid=%0d C0=%h D0=%h rd=%h vld=%b required ready=1 rest 0",
                  bus.key_ready, busy, keys_valid, ll_start, ll_keyid, ll_C0, ll_D0, bus.rd_data, bus.rd_vld);
      end
      tick();
      rst_n = 1'b1;
      tick();
      load_key(SPEC_KEY);
      wait_keys_valid(cyc);
      do_read(0, 1'b0, d, v);
      tests++;
      if (d !== SPEC_K1) begin
         failed++;
         $display("FAIL post_reset_K1: data=%h required %h", d, SPEC_K1);
      end
      do_read(15, 1'b0, d, v);
      tests++;
      if (d !== SPEC_K16) begin
         failed++;
         $display("FAIL post_reset_K16: data=%h required %h", d, SPEC_K16);
      end
      $display("[TB] reset at n=9 then reload done");
   endtask

   task automatic test_parity_random();
      logic [63:0] key, mask;
      logic [47:0] d;
      logic        v;
      int          cyc;
      for (int it = 0; it < 4; it++) begin
         key  = (it == 0) ? SPEC_KEY : {$urandom, $urandom};
         mask = (it == 0) ? PARITY : ({$urandom, $urandom} & PARITY);
         compute_ref(key);
         load_key(key ^ mask);
         tests++;
         if ({ll_C0, ll_D0} !== {exp_c0, exp_d0}) begin
            failed++;
            $display("FAIL parity_pc1: C0=%h D0=%h required %h %h", ll_C0, ll_D0, exp_c0, exp_d0);
         end
         wait_keys_valid(cyc);
         for (int r = 0; r < 16; r++) begin
            bit dec = 1'($urandom_range(0, 1));
            int kn = dec ? 16 - r : r + 1;
            do_read(r, dec, d, v);
            tests++;
            if (d !== exp_k[kn-1]) begin
               failed++;
               $display("FAIL parity_K%0d: key=%h mask=%h data=%h required %h", kn, key, mask, d, exp_k[kn-1]);
            end
         end
         $display("[TB] key %h with parity mask %h checked", key, mask);
      end
   endtask

   initial begin
      test_reset();
      test_load_timing();
      test_read_forward();
      test_reverse_b2b();
      test_busy_ignore();
      test_reset_mid();
      test_parity_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
